adc_qsys_capture_ram: RTL and testbench

ADC_QSYS_CAPTURE_RAM -- requirements
Module: adc_qsys_capture_ram

---
 rtl/adc_qsys_capture_pkg.sv | 14 +
 rtl/adc_qsys_capture_dpram.sv | 52 +++++
 rtl/adc_qsys_capture_ram.sv | 145 ++++++++++++++
 tb/tb_adc_qsys_capture_ram.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_qsys_capture_pkg.sv
// Shared types and constants for the ADC capture RAM: capture FSM states and
// the supported range of Avalon-MM read latencies.
package adc_qsys_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_e;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 2;

endpackage

// File: rtl/adc_qsys_capture_dpram.sv
// Inferred true dual-port RAM: port A is the byte-enabled Avalon-MM side with a
// registered read, port B is the write-only streaming capture side.
module adc_qsys_capture_dpram
    import adc_qsys_capture_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32000,
    parameter int ADDR_W = 15
) (
    input  logic                clk,
    input  logic                a_we,
    input  logic                a_re,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    input  logic                b_we,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata
);

    localparam int              BYTES   = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] a_rdata_q;
    logic              a_in_range;

    // MM addresses beyond DEPTH are silently dropped for writes.
    assign a_in_range = {1'b0, a_addr} < DEPTH_C;
    assign a_rdata    = a_rdata_q;

    // NOTE: the array has no reset; contents must survive reset, and a reset
    // term would stop the tools from mapping it onto block RAM.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking read and writes on the same edge give read-old-data.
        if (a_re) begin
            a_rdata_q <= mem[a_addr];
        end
        if (a_we && a_in_range) begin
            for (int i = 0; i < BYTES; i++) begin
                if (a_be[i]) begin
                    mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
                end
            end
        end
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
    end

endmodule

// File: rtl/adc_qsys_capture_ram.sv
// ADC sample capture buffer: Avalon-ST samples are written into a RAM that is
// also readable and writable over a zero-wait-state Avalon-MM slave.
module adc_qsys_capture_ram
    import adc_qsys_capture_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 32000,
    parameter int ADDR_W       = 15,
    parameter int SAMPLE_W     = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    input  logic [SAMPLE_W-1:0] st_data,
    input  logic                st_valid,
    output logic                st_ready,
    input  logic                arm,
    input  logic                stop,
    input  logic [ADDR_W:0]     capture_len,
    output logic                busy,
    output logic                done,
    output logic                wrapped,
    output logic [ADDR_W-1:0]   wr_ptr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam int                EFF_LATENCY = (READ_LATENCY <= READ_LATENCY_MIN) ?
                                                READ_LATENCY_MIN : READ_LATENCY_MAX;

    cap_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              wrapped_q, wrapped_d;
    logic              rd_valid1_q, rd_valid1_d;
    logic              st_accept, mm_wr, mm_rd, mm_wr_keep;
    logic [DATA_W-1:0] ram_rdata;

    assign st_accept   = st_valid && (state_q == ST_CAPTURE);
    assign mm_wr       = chipselect && write;
    assign mm_rd       = chipselect && read && !write;
    // A same-address collision with the capture stream drops the MM write.
    assign mm_wr_keep  = mm_wr && !(st_accept && (address == wr_ptr_q));
    assign rd_valid1_d = mm_rd;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        len_d     = len_q;
        wrapped_d = wrapped_q;
        if (arm) begin
            state_d   = ST_CAPTURE;
            wr_ptr_d  = '0;
            count_d   = '0;
            wrapped_d = 1'b0;
            len_d     = capture_len;
        end else if (state_q == ST_CAPTURE) begin
            if (st_accept) begin
                count_d = count_q + (ADDR_W + 1)'(1);
                if (wr_ptr_q == LAST_ADDR) begin
                    wr_ptr_d  = '0;
                    wrapped_d = 1'b1;
                end else begin
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                end
                if ((len_q != '0) && (count_d == len_q)) begin
                    state_d = ST_DONE;
                end
            end
            if (stop) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            len_q       <= '0;
            wrapped_q   <= 1'b0;
            rd_valid1_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            len_q       <= len_d;
            wrapped_q   <= wrapped_d;
            rd_valid1_q <= rd_valid1_d;
        end
    end

    assign st_ready = (state_q == ST_CAPTURE);
    assign busy     = (state_q == ST_CAPTURE);
    assign done     = (state_q == ST_DONE);
    assign wrapped  = wrapped_q;
    assign wr_ptr   = wr_ptr_q;

    adc_qsys_capture_dpram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .a_we    (mm_wr_keep),
        .a_re    (mm_rd),
        .a_addr  (address),
        .a_be    (byteenable),
        .a_wdata (writedata),
        .a_rdata (ram_rdata),
        .b_we    (st_accept),
        .b_addr  (wr_ptr_q),
        .b_wdata (DATA_W'(st_data))
    );

    // The RAM read register supplies the first clock of latency.
    if (EFF_LATENCY == READ_LATENCY_MIN) begin : g_lat1
        assign readdata      = ram_rdata;
        assign readdatavalid = rd_valid1_q;
    end else begin : g_lat2
        logic [DATA_W-1:0] rdata2_q;
        logic              rd_valid2_q;
        always_ff @(posedge clk) begin
            if (reset) begin
                rd_valid2_q <= 1'b0;
            end else begin
                rd_valid2_q <= rd_valid1_q;
            end
            rdata2_q <= ram_rdata;
        end
        assign readdata      = rdata2_q;
        assign readdatavalid = rd_valid2_q;
    end

endmodule

// File: tb/tb_adc_qsys_capture_ram.sv
// Self-checking bench for adc_qsys_capture_ram: a default instance (latency 2)
// and a small DEPTH=8 instance (latency 1) checked against an array model.
module tb_adc_qsys_capture_ram;

    localparam int LAT = 2;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] address;
    logic [3:0]  byteenable;
    logic        chipselect, read, write;
    logic [31:0] writedata, readdata;
    logic        readdatavalid;
    logic [15:0] st_data;
    logic        st_valid, st_ready;
    logic        arm, stop;
    logic [15:0] capture_len;
    logic        busy, done, wrapped;
    logic [14:0] wr_ptr;

    logic [2:0]  b_address;
    logic [3:0]  b_byteenable;
    logic        b_chipselect, b_read, b_write;
    logic [31:0] b_writedata, b_readdata;
    logic        b_readdatavalid;
    logic [15:0] b_st_data;
    logic        b_st_valid, b_st_ready;
    logic        b_arm, b_stop;
    logic [3:0]  b_capture_len;
    logic        b_busy, b_done, b_wrapped;
    logic [2:0]  b_wr_ptr;

    logic [31:0] model_mem [0:31999];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    adc_qsys_capture_ram dut (
        .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
        .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
        .readdata(readdata), .readdatavalid(readdatavalid), .st_data(st_data),
        .st_valid(st_valid), .st_ready(st_ready), .arm(arm), .stop(stop),
        .capture_len(capture_len), .busy(busy), .done(done), .wrapped(wrapped),
        .wr_ptr(wr_ptr)
    );

    adc_qsys_capture_ram #(.DEPTH(8), .ADDR_W(3), .READ_LATENCY(1)) dut8 (
        .clk(clk), .reset(reset), .address(b_address), .byteenable(b_byteenable),
        .chipselect(b_chipselect), .read(b_read), .write(b_write), .writedata(b_writedata),
        .readdata(b_readdata), .readdatavalid(b_readdatavalid), .st_data(b_st_data),
        .st_valid(b_st_valid), .st_ready(b_st_ready), .arm(b_arm), .stop(b_stop),
        .capture_len(b_capture_len), .busy(b_busy), .done(b_done), .wrapped(b_wrapped),
        .wr_ptr(b_wr_ptr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mm_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] be);
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        address = a; writedata = d; byteenable = be;
        step();
        chipselect = 1'b0; write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) model_mem[a][i*8 +: 8] = d[i*8 +: 8];
        end
    endtask

    // Issues one read and returns the data and the number of clocks until
    // readdatavalid (-1 if it never came within the bound).
    task automatic mm_read(input logic [14:0] a, output logic [31:0] d, output int lat);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
        step();
        chipselect = 1'b0; read = 1'b0;
        lat = 1;
        while (!readdatavalid && lat < 8) begin step(); lat++; end
        if (!readdatavalid) lat = -1;
        d = readdata;
    endtask

    task automatic b_mm_read(input logic [2:0] a, output logic [31:0] d, output int lat);
        b_chipselect = 1'b1; b_read = 1'b1; b_write = 1'b0; b_address = a;
        step();
        b_chipselect = 1'b0; b_read = 1'b0;
        lat = 1;
        while (!b_readdatavalid && lat < 8) begin step(); lat++; end
        if (!b_readdatavalid) lat = -1;
        d = b_readdata;
    endtask

    task automatic send_sample(input logic [15:0] s);
        int n;
        repeat ($urandom_range(0, 2)) step();
        st_data = s; st_valid = 1'b1; n = 0;
        while (!st_ready && n < 20) begin step(); n++; end
        checks++;
        if (!st_ready) begin errors++; $display("FAIL st_ready_wait: st_ready=%0b expected 1", st_ready); end
        step();
        st_valid = 1'b0;
    endtask

    task automatic b_send_sample(input logic [15:0] s);
        int n;
        b_st_data = s; b_st_valid = 1'b1; n = 0;
        while (!b_st_ready && n < 20) begin step(); n++; end
        checks++;
        if (!b_st_ready) begin errors++; $display("FAIL b_st_ready_wait: st_ready=%0b expected 1", b_st_ready); end
        step();
        b_st_valid = 1'b0;
    endtask

    task automatic arm_capture(input logic [15:0] len);
        arm = 1'b1; capture_len = len;
        step();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL reset_st_ready: got %0b expected 0", st_ready); end
        checks++; if (readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_rdv: got %0b expected 0", readdatavalid); end
        checks++; if (wr_ptr !== 15'd0) begin errors++; $display("FAIL reset_wr_ptr: got %0d expected 0", wr_ptr); end
        checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL reset_wrapped: got %0b expected 0", wrapped); end
        checks++; if (b_busy !== 1'b0 || b_done !== 1'b0) begin errors++; $display("FAIL reset_b_state: busy %0b done %0b expected 0 0", b_busy, b_done); end
        checks++; if (b_wr_ptr !== 3'd0 || b_wrapped !== 1'b0) begin errors++; $display("FAIL reset_b_ptr: wr_ptr %0d wrapped %0b expected 0 0", b_wr_ptr, b_wrapped); end
    endtask

    task automatic test_byteenable();
        logic [31:0] d;
        logic [14:0] a;
        int lat;
        mm_write(15'd5, 32'hFFFF_FFFF, 4'hF);
        mm_write(15'd5, 32'hA5A5_1234, 4'b0011);
        mm_read(15'd5, d, lat);
        checks++; if (d !== 32'hFFFF_1234) begin errors++; $display("FAIL be_addr5_data: got %h expected ffff1234", d); end
        checks++; if (lat !== LAT) begin errors++; $display("FAIL be_addr5_latency: got %0d expected %0d", lat, LAT); end
        for (int i = 0; i < 6; i++) begin
            a = 15'(100 + i);
            mm_write(a, $urandom, 4'hF);
            mm_write(a, $urandom, 4'($urandom_range(0, 15)));
            mm_read(a, d, lat);
            checks++; if (d !== model_mem[a] || lat !== LAT) begin
                errors++; $display("FAIL be_random[%0d]: got %h lat %0d expected %h lat %0d", a, d, lat, model_mem[a], LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        int j;
        bit exp_v;
        for (int i = 0; i < 8; i++) mm_write(15'(i), $urandom, 4'hF);
        for (int k = 0; k < 8 + LAT; k++) begin
            chipselect = (k < 8); read = (k < 8); write = 1'b0; address = 15'(k);
            step();
            j = k - (LAT - 1);
            exp_v = (j >= 0) && (j < 8);
            checks++; if (readdatavalid !== exp_v) begin errors++; $display("FAIL b2b_valid[cyc %0d]: got %0b expected %0b", k, readdatavalid, exp_v); end
            if (exp_v) begin
                checks++; if (readdata !== model_mem[j]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", j, readdata, model_mem[j]); end
            end
        end
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic test_random_mm();
        rd_exp_t pend[$];
        rd_exp_t e;
        int cyc = 0;
        int op;
        bit exp_v;
        for (int i = 200; i < 232; i++) mm_write(15'(i), $urandom, 4'hF);
        for (int k = 0; k < 200 + LAT; k++) begin
            op = (k < 200) ? $urandom_range(0, 4) : -1;
            chipselect = (op > 0); read = (op == 1 || op == 2 || op == 4 || op == 0);
            write = (op == 3 || op == 4 || op == 0);
            address = 15'($urandom_range(200, 231));
            writedata = $urandom; byteenable = 4'($urandom_range(0, 15));
            if (chipselect && read && !write) begin
                e.due = cyc + LAT; e.data = model_mem[address]; pend.push_back(e);
            end
            if (chipselect && write) begin
                for (int b = 0; b < 4; b++) if (byteenable[b]) model_mem[address][b*8 +: 8] = writedata[b*8 +: 8];
            end
            step();
            cyc++;
            exp_v = (pend.size() > 0) && (pend[0].due == cyc);
            checks++; if (readdatavalid !== exp_v) begin errors++; $display("FAIL rand_valid[cyc %0d]: got %0b expected %0b", cyc, readdatavalid, exp_v); end
            if (exp_v) begin
                e = pend.pop_front();
                checks++; if (readdata !== e.data) begin errors++; $display("FAIL rand_data[cyc %0d]: got %h expected %h", cyc, readdata, e.data); end
            end
        end
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
    endtask

    task automatic test_capture_len();
        logic [31:0] d;
        int lat;
        arm_capture(16'd4);
        capture_len = 16'd2;
        checks++; if (busy !== 1'b1 || st_ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL cap4_armed: busy %0b ready %0b done %0b expected 1 1 0", busy, st_ready, done);
        end
        checks++; if (wr_ptr !== 15'd0) begin errors++; $display("FAIL cap4_ptr0: got %0d expected 0", wr_ptr); end
        for (int i = 0; i < 4; i++) begin
            send_sample(16'(16'h0011 + i));
            model_mem[i] = 32'(16'h0011 + i);
        end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL cap4_done: done %0b busy %0b expected 1 0", done, busy); end
        checks++; if (wr_ptr !== 15'd4) begin errors++; $display("FAIL cap4_wr_ptr: got %0d expected 4", wr_ptr); end
        checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL cap4_ready_after: got %0b expected 0", st_ready); end
        st_valid = 1'b1; st_data = 16'h0099;
        repeat (2) step();
        st_valid = 1'b0;
        checks++; if (wr_ptr !== 15'd4) begin errors++; $display("FAIL cap4_no_extra: got %0d expected 4", wr_ptr); end
        for (int i = 0; i < 5; i++) begin
            mm_read(15'(i), d, lat);
            checks++; if (d !== model_mem[i]) begin errors++; $display("FAIL cap4_mem[%0d]: got %h expected %h", i, d, model_mem[i]); end
        end
    endtask

    task automatic test_stop_restart();
        logic [31:0] d;
        logic [15:0] s;
        int lat, n;
        n = $urandom_range(5, 12);
        arm_capture(16'd0);
        for (int i = 0; i < n - 1; i++) begin
            s = 16'($urandom); send_sample(s); model_mem[i] = {16'h0, s};
        end
        s = 16'($urandom);
        st_valid = 1'b1; st_data = s; stop = 1'b1;
        step();
        st_valid = 1'b0; stop = 1'b0;
        model_mem[n-1] = {16'h0, s};
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL stop_done: done %0b busy %0b expected 1 0", done, busy); end
        checks++; if (wr_ptr !== 15'(n)) begin errors++; $display("FAIL stop_wr_ptr: got %0d expected %0d", wr_ptr, n); end
        for (int i = 0; i < n; i++) begin
            mm_read(15'(i), d, lat);
            checks++; if (d !== model_mem[i]) begin errors++; $display("FAIL stop_mem[%0d]: got %h expected %h", i, d, model_mem[i]); end
        end
        arm_capture(16'd0);
        for (int i = 0; i < 3; i++) begin
            s = 16'($urandom); send_sample(s); model_mem[i] = {16'h0, s};
        end
        arm_capture(16'd0);
        checks++; if (wr_ptr !== 15'd0 || busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL rearm_restart: wr_ptr %0d busy %0b done %0b expected 0 1 0", wr_ptr, busy, done);
        end
        stop = 1'b1; step(); stop = 1'b0;
        checks++; if (done !== 1'b1 || wr_ptr !== 15'd0) begin errors++; $display("FAIL rearm_stop: done %0b wr_ptr %0d expected 1 0", done, wr_ptr); end
    endtask

    task automatic test_collision();
        logic [31:0] d, old;
        logic [15:0] s;
        int lat;
        old = model_mem[0];
        s = 16'($urandom);
        arm_capture(16'd1);
        st_valid = 1'b1; st_data = s; chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 15'd0;
        step();
        st_valid = 1'b0; chipselect = 1'b0; read = 1'b0;
        lat = 1;
        while (!readdatavalid && lat < 8) begin step(); lat++; end
        checks++; if (readdata !== old || lat !== LAT) begin errors++; $display("FAIL rd_old_data: got %h lat %0d expected %h lat %0d", readdata, lat, old, LAT); end
        model_mem[0] = {16'h0, s};
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL len1_done: got %0b expected 1", done); end
        s = 16'($urandom);
        arm_capture(16'd1);
        st_valid = 1'b1; st_data = s; chipselect = 1'b1; write = 1'b1; address = 15'd0;
        writedata = 32'hDEAD_BEEF; byteenable = 4'hF;
        step();
        st_valid = 1'b0; chipselect = 1'b0; write = 1'b0;
        model_mem[0] = {16'h0, s};
        mm_read(15'd0, d, lat);
        checks++; if (d !== model_mem[0]) begin errors++; $display("FAIL collide_st_wins: got %h expected %h", d, model_mem[0]); end
        s = 16'($urandom);
        arm_capture(16'd1);
        st_valid = 1'b1; st_data = s; chipselect = 1'b1; write = 1'b1; address = 15'd50;
        writedata = $urandom; byteenable = 4'hF;
        step();
        st_valid = 1'b0; chipselect = 1'b0; write = 1'b0;
        model_mem[0] = {16'h0, s}; model_mem[50] = writedata;
        mm_read(15'd50, d, lat);
        checks++; if (d !== model_mem[50]) begin errors++; $display("FAIL parallel_mm: got %h expected %h", d, model_mem[50]); end
        mm_read(15'd0, d, lat);
        checks++; if (d !== model_mem[0]) begin errors++; $display("FAIL parallel_st: got %h expected %h", d, model_mem[0]); end
    endtask

    task automatic test_reset_midcapture();
        logic [31:0] d;
        logic [15:0] s;
        int lat;
        bit seen = 1'b0;
        arm_capture(16'd0);
        for (int i = 0; i < 3; i++) begin
            s = 16'($urandom); send_sample(s); model_mem[i] = {16'h0, s};
        end
        chipselect = 1'b1; read = 1'b1; address = 15'd1;
        step();
        chipselect = 1'b0; read = 1'b0;
        seen |= readdatavalid;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin seen |= readdatavalid; step(); end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_flush_rdv: got %0b expected 0", seen); end
        checks++; if (busy !== 1'b0 || done !== 1'b0 || st_ready !== 1'b0) begin
            errors++; $display("FAIL rst_idle: busy %0b done %0b ready %0b expected 0 0 0", busy, done, st_ready);
        end
        checks++; if (wr_ptr !== 15'd0) begin errors++; $display("FAIL rst_wr_ptr: got %0d expected 0", wr_ptr); end
        for (int i = 0; i < 3; i++) begin
            mm_read(15'(i), d, lat);
            checks++; if (d !== model_mem[i]) begin errors++; $display("FAIL rst_mem[%0d]: got %h expected %h", i, d, model_mem[i]); end
        end
    endtask

    task automatic test_wrap_depth8();
        logic [15:0] s [10];
        logic [31:0] exp_mem [8];
        logic [31:0] d;
        int lat;
        b_arm = 1'b1; b_capture_len = 4'd10;
        step();
        b_arm = 1'b0; b_capture_len = 4'd3;
        for (int k = 0; k < 10; k++) begin
            s[k] = 16'($urandom);
            b_send_sample(s[k]);
            exp_mem[k % 8] = {16'h0, s[k]};
        end
        checks++; if (b_done !== 1'b1 || b_st_ready !== 1'b0) begin errors++; $display("FAIL d8_done: done %0b ready %0b expected 1 0", b_done, b_st_ready); end
        checks++; if (b_wrapped !== 1'b1) begin errors++; $display("FAIL d8_wrapped: got %0b expected 1", b_wrapped); end
        checks++; if (b_wr_ptr !== 3'd2) begin errors++; $display("FAIL d8_wr_ptr: got %0d expected 2", b_wr_ptr); end
        for (int a = 0; a < 8; a++) begin
            b_mm_read(3'(a), d, lat);
            checks++; if (d !== exp_mem[a] || lat !== 1) begin
                errors++; $display("FAIL d8_mem[%0d]: got %h lat %0d expected %h lat 1", a, d, lat, exp_mem[a]);
            end
        end
        b_arm = 1'b1; b_capture_len = 4'd0;
        step();
        b_arm = 1'b0;
        checks++; if (b_wrapped !== 1'b0 || b_busy !== 1'b1) begin errors++; $display("FAIL d8_rearm: wrapped %0b busy %0b expected 0 1", b_wrapped, b_busy); end
        b_stop = 1'b1; step(); b_stop = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        address = '0; byteenable = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = '0;
        st_data = '0; st_valid = 1'b0; arm = 1'b0; stop = 1'b0; capture_len = '0;
        b_address = '0; b_byteenable = '0; b_chipselect = 1'b0; b_read = 1'b0; b_write = 1'b0;
        b_writedata = '0; b_st_data = '0; b_st_valid = 1'b0; b_arm = 1'b0; b_stop = 1'b0;
        b_capture_len = '0;
        test_reset();
        test_byteenable();
        test_back_to_back();
        test_random_mm();
        test_capture_len();
        test_stop_restart();
        test_collision();
        test_reset_midcapture();
        test_wrap_depth8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
